dispatch_scheduler: RTL and testbench
=====================================

Name: dispatch_scheduler

Overview:
- Sits between the in-order instruction queue and the per-unit reservation stations (FX, FP, VX, CR, LS, Branch).
- Pops the queue head in program order and routes each entry to its functional unit by funcUnitType.
- Per-unit credit counters track reservation-station free slots and provide back-pressure.
- Also sequences pipeline flushes by draining the queue without dispatching.

Parameters:
- funcUnitCodeSize, 3, width of unit-type code; numUnits = 2**funcUnitCodeSize.
- instructionCounterWidth, 64, major ID width.
- instMinIdWidth, 5, minor ID width.
- creditWidth, 3, width of each credit counter.
- unitCredits, 4, reset and maximum credit per unit; must be ≤ 2**creditWidth-1.
- unitPresentMask, 8'b1111_1010, bit i set means unit ID i exists. Bit 0 is the MSB, per the codebase's [0:N-1] ordering. Default set: units 0,1,2,3,4,6.

Ports:
- clock_i in 1: clock.
- reset_i in 1: reset; asynchronous and active-low.
- queueEmpty_i in 1: queue isEmpty.
- queueFuncUnitType_i in 3: head entry unit type. The queue is show-ahead: the head entry is valid whenever queueEmpty_i=0.
- queueMajID_i in 64: head major ID.
- queueMinID_i in 5: head minor ID.
- queueReadEnable_o out 1: pops the head at this clock edge.
- unitCreditReturn_i in numUnits: one pulse per freed reservation slot; bit i = unit i.
- flush_i in 1: level flush request.
- unitDispatch_o out numUnits: one-hot dispatch strobe, registered.
- dispatchMajID_o out 64: major ID of the dispatched entry.
- dispatchMinID_o out 5: minor ID of the dispatched entry.
- flushing_o out 1: high while in FLUSH.
- illegalUnit_o out 1: sticky; an entry targeted an absent unit.
- creditOverflow_o out 1: sticky; a credit was returned to a full counter.

Behaviour:
- Reset (reset_i=0, async):
  - State=RUN; all credits=unitCredits.
  - All outputs 0; ID outputs 0.
- RUN:
  - Let t = queueFuncUnitType_i. Pop when queueEmpty_i=0 AND flush_i=0 AND (credit[t]>0 OR unitPresentMask[t]=0).
  - Pop is combinational: queueReadEnable_o=1 in the same cycle.
  - Next edge for a present unit: unitDispatch_o[t]=1 and the ID outputs load the head IDs; latency is 1 cycle from the head being visible.
  - Otherwise unitDispatch_o=0 next cycle; ID outputs hold their last values.
  - Absent unit: entry popped, not dispatched, illegalUnit_o set.
  - Strict in order: a blocked head blocks everything behind it; there is no bypass.
  - At most one pop per cycle.
- Credits, per unit each edge:
  - Dispatch only: −1. Return only: +1. Both: unchanged.
  - Return at unitCredits: saturate and set creditOverflow_o.
  - A returned credit is usable next cycle only; there is no combinational bypass from unitCreditReturn_i to queueReadEnable_o.
- FLUSH:
  - Entered from RUN when flush_i=1; flushing_o=1 from the next edge.
  - No dispatch occurs in the entry cycle.
  - In FLUSH: queueReadEnable_o = ~queueEmpty_i every cycle; unitDispatch_o=0; credits still accept returns.
  - FLUSH→RUN when flush_i=0 AND queueEmpty_i=1. If flush_i drops while the queue is non-empty, draining continues until empty.
- Sticky errors clear only on reset.
- Reset mid-operation: an in-flight dispatch strobe is dropped. Credits reinitialise; reservation stations are reset by the same signal.

Optional Feature:
- Macro DISPATCH_PERF_COUNTERS_EN.
- When defined, adds outputs dispatchCount_o (32) and stallCount_o (32).
  - dispatchCount_o increments on every unitDispatch_o strobe.
  - stallCount_o increments on each RUN cycle where queueEmpty_i=0, flush_i=0 and the head is credit-blocked.
  - Both wrap at 2**32 and reset to 0.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - unit ID constants FXUnitId=0, FPUnitId=1, VXUnitId=2, CRUnitId=3, LSUnitId=4, BranchUnitID=6;
  - funcUnitCodeSize;
  - the state encoding RUN=1'b0, FLUSH=1'b1.
- One natural sub-module, credit_counter:
  - a single saturating up/down counter with dec, inc, hasCredit and overflow pulse;
  - instantiated numUnits times by generate.

Test Plan:
- Reset: all credits at 4. Push FX head (type 0), majID=5, minID=0 → queueReadEnable_o=1 same cycle; next cycle unitDispatch_o=8'b1000_0000, dispatchMajID_o=5.
- Five FP entries, no returns → four dispatches on consecutive cycles; the 5th is held (queueReadEnable_o=0). Pulse unitCreditReturn_i[1] once → the 5th dispatches one cycle after the pulse cycle.
- FP head blocked at 0 credits, FX entry behind it → the FX entry is not dispatched until FP drains (in-order check).
- Head type 5 (absent) → popped, unitDispatch_o stays 0, illegalUnit_o=1 and stays 1 for later valid traffic.
- Queue holds 6 entries, assert flush_i for 1 cycle → 6 consecutive pops, zero dispatches; flushing_o falls the cycle after queueEmpty_i=1; credits unchanged at 4.
- Return a credit to unit 0 at 4 credits → creditOverflow_o=1 and credit stays 4. Assert reset_i=0 mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/dispatch_scheduler_pkg.sv
// Shared definitions for the dispatch scheduler: unit-type code width,
// functional unit IDs and the scheduler state encoding.
package dispatch_scheduler_pkg;

    localparam int funcUnitCodeSize = 3;
    localparam int numUnits         = 2 ** funcUnitCodeSize;

    localparam logic [funcUnitCodeSize-1:0] FXUnitId     = 3'd0;
    localparam logic [funcUnitCodeSize-1:0] FPUnitId     = 3'd1;
    localparam logic [funcUnitCodeSize-1:0] VXUnitId     = 3'd2;
    localparam logic [funcUnitCodeSize-1:0] CRUnitId     = 3'd3;
    localparam logic [funcUnitCodeSize-1:0] LSUnitId     = 3'd4;
    localparam logic [funcUnitCodeSize-1:0] BranchUnitID = 3'd6;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage

// File: rtl/dispatch_scheduler_credit_counter.sv
// Saturating up/down credit counter tracking the free slots of one
// reservation station. Returning a credit to a full counter keeps it full
// and raises a single-cycle overflow pulse.
module credit_counter #(
    parameter int creditWidth = 3,
    parameter int unitCredits = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic dec,
    input  logic inc,
    output logic has_credit,
    output logic overflow
);

    localparam logic [creditWidth-1:0] MAX_CREDIT = creditWidth'(unitCredits);

    logic [creditWidth-1:0] count;

    assign has_credit = (count != '0);
    assign overflow   = inc & ~dec & (count == MAX_CREDIT);

    // Count down on dispatch, up on return, hold when both or at saturation.
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count <= MAX_CREDIT;
        end else if (dec && !inc && has_credit) begin
            count <= count - 1'b1;
        end else if (inc && !dec && (count != MAX_CREDIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order dispatch scheduler: pops the instruction queue head and routes it
// to its functional unit under per-unit credit back-pressure; sequences
// flushes by draining the queue without dispatching.
// Optional build macro DISPATCH_PERF_COUNTERS_EN adds dispatch/stall counters.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int                  instructionCounterWidth = 64,
    parameter int                  instMinIdWidth          = 5,
    parameter int                  creditWidth             = 3,
    parameter int                  unitCredits             = 4,
    parameter logic [0:numUnits-1] unitPresentMask         = 8'b1111_1010
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               queueEmpty_i,
    input  logic [funcUnitCodeSize-1:0]        queueFuncUnitType_i,
    input  logic [instructionCounterWidth-1:0] queueMajID_i,
    input  logic [instMinIdWidth-1:0]          queueMinID_i,
    output logic                               queueReadEnable_o,
    input  logic [0:numUnits-1]                unitCreditReturn_i,
    input  logic                               flush_i,
    output logic [0:numUnits-1]                unitDispatch_o,
    output logic [instructionCounterWidth-1:0] dispatchMajID_o,
    output logic [instMinIdWidth-1:0]          dispatchMinID_o,
    output logic                               flushing_o,
    output logic                               illegalUnit_o,
    output logic                               creditOverflow_o
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                        dispatchCount_o,
    output logic [31:0]                        stallCount_o
`endif
);

    sched_state_t        state;
    logic [0:numUnits-1] has_credit;
    logic [0:numUnits-1] overflow;
    logic [0:numUnits-1] dispatch_now;
    logic                head_present;
    logic                head_ready;
    logic                run_eligible;
    logic                pop_run;

    assign head_present = unitPresentMask[queueFuncUnitType_i];
    // Absent units never block: their entries are popped and flagged.
    assign head_ready   = has_credit[queueFuncUnitType_i] | ~head_present;
    assign run_eligible = reset_i & (state == RUN) & ~queueEmpty_i & ~flush_i;
    assign pop_run      = run_eligible & head_ready;

    // Decode the pop into a one-hot dispatch and drive the queue pop.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dispatch_now = '0;
        if (pop_run && head_present) begin
            dispatch_now[queueFuncUnitType_i] = 1'b1;
        end
        if (state == FLUSH) begin
            queueReadEnable_o = reset_i & ~queueEmpty_i;
        end else begin
            queueReadEnable_o = pop_run;
        end
    end

    for (genvar gi = 0; gi < numUnits; gi++) begin : g_credit
        credit_counter #(
            .creditWidth (creditWidth),
            .unitCredits (unitCredits)
        ) u_credit (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .dec        (dispatch_now[gi]),
            .inc        (unitCreditReturn_i[gi]),
            .has_credit (has_credit[gi]),
            .overflow   (overflow[gi])
        );
    end

    // RUN/FLUSH sequencing with registered dispatch strobe, IDs and sticky errors.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state            <= RUN;
            unitDispatch_o   <= '0;
            dispatchMajID_o  <= '0;
            dispatchMinID_o  <= '0;
            flushing_o       <= 1'b0;
            illegalUnit_o    <= 1'b0;
            creditOverflow_o <= 1'b0;
        end else begin
            if (|overflow) begin
                creditOverflow_o <= 1'b1;
            end
            case (state)
                RUN: begin
                    unitDispatch_o <= dispatch_now;
                    if (pop_run && head_present) begin
                        dispatchMajID_o <= queueMajID_i;
                        dispatchMinID_o <= queueMinID_i;
                    end
                    if (pop_run && !head_present) begin
                        illegalUnit_o <= 1'b1;
                    end
                    if (flush_i) begin
                        state      <= FLUSH;
                        flushing_o <= 1'b1;
                    end
                end
                FLUSH: begin
                    unitDispatch_o <= '0;
                    if (!flush_i && queueEmpty_i) begin
                        state      <= RUN;
                        flushing_o <= 1'b0;
                    end
                end
                default: begin
                    state          <= RUN;
                    unitDispatch_o <= '0;
                    flushing_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic stall_now;
    assign stall_now = run_eligible & ~head_ready;

    // Free-running wrap-around counters of dispatches and credit stalls.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            dispatchCount_o <= '0;
            stallCount_o    <= '0;
        end else begin
            if (|dispatch_now) begin
                dispatchCount_o <= dispatchCount_o + 32'd1;
            end
            if (stall_now) begin
                stallCount_o <= stallCount_o + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed testbench for dispatch_scheduler: models the show-ahead queue and
// checks dispatch strobes, IDs, credits, flush and sticky errors against
// hand-computed expectations.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        queueEmpty_i;
    logic [2:0]  queueFuncUnitType_i;
    logic [63:0] queueMajID_i;
    logic [4:0]  queueMinID_i;
    logic        queueReadEnable_o;
    logic [0:7]  unitCreditReturn_i;
    logic        flush_i;
    logic [0:7]  unitDispatch_o;
    logic [63:0] dispatchMajID_o;
    logic [4:0]  dispatchMinID_o;
    logic        flushing_o;
    logic        illegalUnit_o;
    logic        creditOverflow_o;
`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [31:0] dispatchCount_o;
    logic [31:0] stallCount_o;
`endif

    dispatch_scheduler dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .queueEmpty_i        (queueEmpty_i),
        .queueFuncUnitType_i (queueFuncUnitType_i),
        .queueMajID_i        (queueMajID_i),
        .queueMinID_i        (queueMinID_i),
        .queueReadEnable_o   (queueReadEnable_o),
        .unitCreditReturn_i  (unitCreditReturn_i),
        .flush_i             (flush_i),
        .unitDispatch_o      (unitDispatch_o),
        .dispatchMajID_o     (dispatchMajID_o),
        .dispatchMinID_o     (dispatchMinID_o),
        .flushing_o          (flushing_o),
        .illegalUnit_o       (illegalUnit_o),
        .creditOverflow_o    (creditOverflow_o)
`ifdef DISPATCH_PERF_COUNTERS_EN
        ,
        .dispatchCount_o     (dispatchCount_o),
        .stallCount_o        (stallCount_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [2:0]  t;
        logic [63:0] maj;
        logic [4:0]  min;
    } entry_t;

    entry_t q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present the model queue head on the show-ahead interface.
    task automatic drive_head();
        if (q.size() == 0) begin
            queueEmpty_i        = 1'b1;
            queueFuncUnitType_i = 3'd0;
            queueMajID_i        = 64'd0;
            queueMinID_i        = 5'd0;
        end else begin
            queueEmpty_i        = 1'b0;
            queueFuncUnitType_i = q[0].t;
            queueMajID_i        = q[0].maj;
            queueMinID_i        = q[0].min;
        end
    endtask

    task automatic push(input logic [2:0] t, input logic [63:0] maj, input logic [4:0] min);
        entry_t e;
        e.t   = t;
        e.maj = maj;
        e.min = min;
        q.push_back(e);
        drive_head();
    endtask

    // One clock: sample the pop request mid-cycle, pop the model after the edge.
    task automatic tick();
        logic re;
        @(negedge clock_i);
        re = queueReadEnable_o;
        @(posedge clock_i);
        #1;
        if (re && q.size() > 0) q.delete(0);
        drive_head();
        #1;
    endtask

    task automatic do_reset();
        reset_i            = 1'b0;
        q.delete();
        flush_i            = 1'b0;
        unitCreditReturn_i = '0;
        drive_head();
        repeat (2) @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
    endtask

    initial begin
        reset_i            = 1'b0;
        flush_i            = 1'b0;
        unitCreditReturn_i = '0;
        drive_head();
        #2;
        check("rst_dispatch", unitDispatch_o, 8'h00);
        check("rst_maj", dispatchMajID_o, 64'd0);
        check("rst_min", dispatchMinID_o, 5'd0);
        check("rst_flushing", flushing_o, 1'b0);
        check("rst_illegal", illegalUnit_o, 1'b0);
        check("rst_overflow", creditOverflow_o, 1'b0);
        check("rst_re", queueReadEnable_o, 1'b0);
        repeat (2) @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;

        // Single FX dispatch, one-cycle latency
        push(FXUnitId, 64'd5, 5'd0);
        #1;
        check("fx_re", queueReadEnable_o, 1'b1);
        tick();
        check("fx_dispatch", unitDispatch_o, 8'h80);
        check("fx_maj", dispatchMajID_o, 64'd5);
        check("fx_min", dispatchMinID_o, 5'd0);
        check("fx_empty_re", queueReadEnable_o, 1'b0);
        tick();
        check("fx_idle", unitDispatch_o, 8'h00);
        check("fx_hold_maj", dispatchMajID_o, 64'd5);

        // Five FP entries against four credits, then one return
        do_reset();
        for (int i = 0; i < 5; i++) push(FPUnitId, 64'(10 + i), 5'(i));
        #1;
        for (int i = 0; i < 4; i++) begin
            check("fp_re", queueReadEnable_o, 1'b1);
            tick();
            check("fp_dispatch", unitDispatch_o, 8'h40);
            check("fp_maj", dispatchMajID_o, 64'(10 + i));
        end
        check("fp_blocked_re", queueReadEnable_o, 1'b0);
        tick();
        check("fp_blocked_dispatch", unitDispatch_o, 8'h00);
        unitCreditReturn_i = 8'h40;
        #1;
        check("fp_no_bypass", queueReadEnable_o, 1'b0);
        tick();
        unitCreditReturn_i = '0;
        #1;
        check("fp_ret_dispatch", unitDispatch_o, 8'h00);
        check("fp_ret_re", queueReadEnable_o, 1'b1);
        tick();
        check("fp5_dispatch", unitDispatch_o, 8'h40);
        check("fp5_maj", dispatchMajID_o, 64'd14);
        check("fp5_min", dispatchMinID_o, 5'd4);

        // Blocked FP head holds back an FX entry
        push(FPUnitId, 64'd20, 5'd0);
        push(FXUnitId, 64'd21, 5'd1);
        #1;
        check("order_re", queueReadEnable_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("order_blocked", unitDispatch_o, 8'h00);
        end
        unitCreditReturn_i = 8'h40;
        tick();
        unitCreditReturn_i = '0;
        #1;
        check("order_re2", queueReadEnable_o, 1'b1);
        tick();
        check("order_fp", unitDispatch_o, 8'h40);
        check("order_fp_maj", dispatchMajID_o, 64'd20);
        check("order_re3", queueReadEnable_o, 1'b1);
        tick();
        check("order_fx", unitDispatch_o, 8'h80);
        check("order_fx_maj", dispatchMajID_o, 64'd21);

        // Absent unit type 5: popped, not dispatched, sticky error
        push(3'd5, 64'd30, 5'd2);
        push(FXUnitId, 64'd31, 5'd3);
        #1;
        check("abs_re", queueReadEnable_o, 1'b1);
        tick();
        check("abs_dispatch", unitDispatch_o, 8'h00);
        check("abs_illegal", illegalUnit_o, 1'b1);
        check("abs_hold_maj", dispatchMajID_o, 64'd21);
        tick();
        check("abs_next_fx", unitDispatch_o, 8'h80);
        check("abs_next_maj", dispatchMajID_o, 64'd31);
        check("abs_sticky", illegalUnit_o, 1'b1);

        // One-cycle flush drains six entries without dispatching
        do_reset();
        check("flush_illegal_clr", illegalUnit_o, 1'b0);
        push(FXUnitId, 64'd40, 5'd0);
        push(FPUnitId, 64'd41, 5'd1);
        push(VXUnitId, 64'd42, 5'd2);
        push(CRUnitId, 64'd43, 5'd3);
        push(LSUnitId, 64'd44, 5'd4);
        push(BranchUnitID, 64'd45, 5'd5);
        flush_i = 1'b1;
        #1;
        check("flush_entry_re", queueReadEnable_o, 1'b0);
        tick();
        flush_i = 1'b0;
        #1;
        check("flush_entry_dispatch", unitDispatch_o, 8'h00);
        check("flushing_set", flushing_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("flush_pop", queueReadEnable_o, 1'b1);
            tick();
            check("flush_no_dispatch", unitDispatch_o, 8'h00);
            check("flush_flushing", flushing_o, 1'b1);
        end
        check("flush_empty_re", queueReadEnable_o, 1'b0);
        tick();
        check("flush_exit", flushing_o, 1'b0);
        for (int i = 0; i < 5; i++) push(FXUnitId, 64'(50 + i), 5'(i));
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_credit_dispatch", unitDispatch_o, 8'h80);
        end
        check("flush_credit_limit", queueReadEnable_o, 1'b0);

        // Credit return to a full counter
        do_reset();
        unitCreditReturn_i = 8'h80;
        #1;
        tick();
        unitCreditReturn_i = '0;
        check("ovf_set", creditOverflow_o, 1'b1);
        tick();
        check("ovf_sticky", creditOverflow_o, 1'b1);
        for (int i = 0; i < 5; i++) push(FXUnitId, 64'(60 + i), 5'(i));
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_dispatch", unitDispatch_o, 8'h80);
        end
        check("ovf_saturated", queueReadEnable_o, 1'b0);

        // Asynchronous reset with a dispatch strobe in flight
        unitCreditReturn_i = 8'h80;
        tick();
        unitCreditReturn_i = '0;
        #1;
        check("mid_re", queueReadEnable_o, 1'b1);
        tick();
        check("mid_dispatch", unitDispatch_o, 8'h80);
        check("mid_maj", dispatchMajID_o, 64'd64);
        reset_i = 1'b0;
        #1;
        check("async_dispatch", unitDispatch_o, 8'h00);
        check("async_maj", dispatchMajID_o, 64'd0);
        check("async_min", dispatchMinID_o, 5'd0);
        check("async_overflow", creditOverflow_o, 1'b0);
        check("async_flushing", flushing_o, 1'b0);
        check("async_re", queueReadEnable_o, 1'b0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
